ex_stage_pipe: RTL and testbench

EX_STAGE_PIPE -- requirements
Module: ex_stage_pipe

---
 rtl/ex_stage_pipe_pkg.sv | 36 +++
 rtl/ex_stage_pipe_muldiv_iter.sv | 83 ++++++++
 rtl/ex_stage_pipe.sv | 165 ++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pipe_pkg.sv
// ex_pkg: shared opcode constants, operand-select encodings and the
// control FSM state enum for the execute stage.
package ex_pkg;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_SLT  = 6'd5;
  localparam logic [5:0] OP_SLL  = 6'd6;
  localparam logic [5:0] OP_SRL  = 6'd7;
  localparam logic [5:0] OP_MULU = 6'd8;
  localparam logic [5:0] OP_DIVU = 6'd9;

  localparam logic [1:0] SEL_A_RS      = 2'd0;
  localparam logic [1:0] SEL_A_NPC     = 2'd1;
  localparam logic [1:0] SEL_A_FWD_MEM = 2'd2;
  localparam logic [1:0] SEL_A_FWD_WB  = 2'd3;

  localparam logic [1:0] SEL_B_RT      = 2'd0;
  localparam logic [1:0] SEL_B_IMM     = 2'd1;
  localparam logic [1:0] SEL_B_FWD_MEM = 2'd2;
  localparam logic [1:0] SEL_B_FWD_WB  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  function automatic logic is_muldiv_op(input logic [5:0] op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_stage_pipe_muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle engine for an unsigned multiply
// (shift-add) or an unsigned divide (restoring).
//   clk, rst      clock, synchronous active-high reset
//   kill          abandons the operation in flight
//   start         loads op_a/op_b; is_div picks the divide
//   done          high in the cycle whose rising edge runs the last step
//   res_lo/res_hi product low/high, or quotient/remainder; both stay
//                 stable after done until the next start
// One step per edge for DATA_W edges after the start edge.
module muldiv_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill,
  input  logic              start,
  input  logic              is_div,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              done,
  output logic [DATA_W-1:0] res_lo,
  output logic [DATA_W-1:0] res_hi
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic              running, div_q;
  logic [CNT_W-1:0]  cnt;
  // acc = product high half / partial remainder,
  // lo  = multiplier shifting out / dividend shifting out + quotient in.
  logic [DATA_W-1:0] acc, lo, opnd;
  logic [DATA_W:0]   sum, shifted, diff;

  assign sum     = {1'b0, acc} + {1'b0, opnd};
  assign shifted = {acc, lo[DATA_W-1]};
  assign diff    = shifted - {1'b0, opnd};
  assign done    = running && (cnt == CNT_W'(DATA_W - 1));
  assign res_lo  = lo;
  assign res_hi  = acc;

  // A zero divisor needs no special case: every trial subtraction
  // succeeds, so the quotient fills with ones and the remainder ends
  // up holding the whole dividend after the same number of steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      div_q   <= 1'b0;
      acc     <= '0;
      lo      <= '0;
      opnd    <= '0;
    end else if (kill) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      div_q   <= is_div;
      acc     <= '0;
      lo      <= is_div ? op_a : op_b;
      opnd    <= is_div ? op_b : op_a;
    end else if (running) begin
      cnt <= cnt + CNT_W'(1);
      if (done) running <= 1'b0;
      if (div_q) begin
        if (!diff[DATA_W]) begin
          acc <= diff[DATA_W-1:0];
          lo  <= {lo[DATA_W-2:0], 1'b1};
        end else begin
          acc <= shifted[DATA_W-1:0];
          lo  <= {lo[DATA_W-2:0], 1'b0};
        end
      end else if (lo[0]) begin
        acc <= sum[DATA_W:1];
        lo  <= {sum[0], lo[DATA_W-1:1]};
      end else begin
        acc <= {1'b0, acc[DATA_W-1:1]};
        lo  <= {acc[0], lo[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage with operand forwarding muxes, a
// single-cycle ALU and an optional iterative MULU/DIVU path.
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         offer handshake
//   alu_op, sel_a, sel_b      opcode and operand-source selects
//   rs/rt/imm/npc, fwd_*      operand sources
//   flush                     cancels accepted / in-flight work
//   out_valid                 one-cycle result pulse
//   out_result/out_hi/out_eq  registered results, held between pulses
//   busy                      multi-cycle op in flight
// Macro EX_STAGE_MULDIV_EN enables MULU/DIVU and the IDLE/BUSY/DONE FSM;
// without it opcodes 8/9 complete as illegal single-cycle ops.
module ex_stage_pipe
  import ex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        alu_op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm_data,
  input  logic [DATA_W-1:0] npc_addr,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic [DATA_W-1:0] fwd_wb_data,
  input  logic [1:0]        sel_a,
  input  logic [1:0]        sel_b,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_hi,
  output logic              out_equal,
  output logic              busy
);

  logic [DATA_W-1:0] op_a, op_b, alu_res;
  logic              op_eq, accept, sc_fire, md_fire, md_eq;
  logic [DATA_W-1:0] md_lo, md_hi;

  always_comb begin
    op_a = rs_data;
    case (sel_a)
      SEL_A_RS:      op_a = rs_data;
      SEL_A_NPC:     op_a = npc_addr;
      SEL_A_FWD_MEM: op_a = fwd_mem_data;
      default:       op_a = fwd_wb_data;
    endcase
  end

  always_comb begin
    op_b = rt_data;
    case (sel_b)
      SEL_B_RT:      op_b = rt_data;
      SEL_B_IMM:     op_b = imm_data;
      SEL_B_FWD_MEM: op_b = fwd_mem_data;
      default:       op_b = fwd_wb_data;
    endcase
  end

  assign op_eq = (op_a == op_b);

  // Illegal opcodes (and 8/9 when the mul/div path is absent) give 0.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD: alu_res = op_a + op_b;
      OP_SUB: alu_res = op_a - op_b;
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLL: alu_res = op_a << op_b[SHAMT_W-1:0];
      OP_SRL: alu_res = op_a >> op_b[SHAMT_W-1:0];
      default: alu_res = '0;
    endcase
  end

`ifdef EX_STAGE_MULDIV_EN
  ex_state_e state, state_nxt;
  logic      start_md, md_done, eq_hold;

  assign accept   = in_valid && in_ready && !flush;
  assign start_md = accept && is_muldiv_op(alu_op);
  assign sc_fire  = accept && !is_muldiv_op(alu_op);
  assign md_fire  = (state == ST_DONE);
  assign md_eq    = eq_hold;

  always_ff @(posedge clk) begin
    if (rst || flush) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_md) state_nxt = ST_BUSY;
      ST_BUSY: if (md_done)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state == ST_BUSY);
  end

  // out_equal for a multi-cycle op reflects the operands at acceptance.
  always_ff @(posedge clk) begin
    if (rst)           eq_hold <= 1'b0;
    else if (start_md) eq_hold <= op_eq;
  end

  muldiv_iter #(.DATA_W(DATA_W)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .kill   (flush),
    .start  (start_md),
    .is_div (alu_op == OP_DIVU),
    .op_a   (op_a),
    .op_b   (op_b),
    .done   (md_done),
    .res_lo (md_lo),
    .res_hi (md_hi)
  );
`else
  assign in_ready = 1'b1;
  assign busy     = 1'b0;
  assign accept   = in_valid && !flush;
  assign sc_fire  = accept;
  assign md_fire  = 1'b0;
  assign md_eq    = 1'b0;
  assign md_lo    = '0;
  assign md_hi    = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_hi     <= '0;
      out_equal  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (!flush) begin
        if (sc_fire) begin
          out_valid  <= 1'b1;
          out_result <= alu_res;
          out_hi     <= '0;
          out_equal  <= op_eq;
        end else if (md_fire) begin
          out_valid  <= 1'b1;
          out_result <= md_lo;
          out_hi     <= md_hi;
          out_equal  <= md_eq;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
module tb_ex_stage_pipe;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [5:0]  alu_op = '0;
  logic [31:0] rs_data = '0, rt_data = '0, imm_data = '0, npc_addr = '0;
  logic [31:0] fwd_mem_data = '0, fwd_wb_data = '0;
  logic [1:0]  sel_a = '0, sel_b = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_equal, busy;
  logic [31:0] out_result, out_hi;

  ex_stage_pipe #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .rs_data(rs_data), .rt_data(rt_data),
    .imm_data(imm_data), .npc_addr(npc_addr),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
    .sel_a(sel_a), .sel_b(sel_b), .flush(flush),
    .out_valid(out_valid), .out_result(out_result), .out_hi(out_hi),
    .out_equal(out_equal), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] hi;
    logic        eq;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every out_valid pulse is matched against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: got out_valid=1 result=%0h expected no pulse", out_result);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, ".result"}, {32'd0, out_result}, {32'd0, e.res});
          chk({e.name, ".hi"},     {32'd0, out_hi},     {32'd0, e.hi});
          chk({e.name, ".equal"},  {63'd0, out_equal},  {63'd0, e.eq});
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [5:0] op,
                       input logic [1:0] sa, input logic [1:0] sbs,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic [31:0] npc,
                       input logic [31:0] fm, input logic [31:0] fw,
                       input bit push, input logic [31:0] er,
                       input logic [31:0] eh, input logic ee);
    exp_t e;
    @(negedge clk);
    alu_op = op; sel_a = sa; sel_b = sbs;
    rs_data = rs; rt_data = rt; imm_data = imm; npc_addr = npc;
    fwd_mem_data = fm; fwd_wb_data = fw;
    in_valid = 1'b1;
    if (push) begin
      e.name = nm; e.res = er; e.hi = eh; e.eq = ee;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble the sources: results must depend only on accepted values.
    rs_data = 32'hDEAD_BEEF; rt_data = 32'h1234_5678; imm_data = 32'h0;
    fwd_mem_data = 32'h5A5A_5A5A; fwd_wb_data = 32'hA5A5_A5A5;
  endtask

  // Single-cycle op: pulse must be visible in the cycle right after acceptance.
  task automatic sc_op(input string nm, input logic [5:0] op,
                       input logic [1:0] sa, input logic [1:0] sbs,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ee);
    logic [31:0] rs, npc, fm, fw, rt, imm;
    rs = '0; npc = '0; fm = '0; fw = '0; rt = '0; imm = '0;
    case (sa)
      2'd0: rs = a; 2'd1: npc = a; 2'd2: fm = a; default: fw = a;
    endcase
    case (sbs)
      2'd0: rt = b; 2'd1: imm = b; 2'd2: fm = b; default: fw = b;
    endcase
    issue(nm, op, sa, sbs, rs, rt, imm, npc, fm, fw, 1'b1, er, 32'd0, ee);
    @(negedge clk);
    chk({nm, ".valid"}, {63'd0, out_valid}, 64'd1);
  endtask

`ifdef EX_STAGE_MULDIV_EN
  // Counts cycles with in_ready low after acceptance; bounded.
  task automatic md_op(input string nm, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [31:0] eh);
    int low;
    logic saw_busy;
    low = 0;
    saw_busy = 1'b0;
    issue(nm, op, SEL_A_RS, SEL_B_RT, a, b, 0, 0, 0, 0, 1'b1, er, eh, a == b);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) saw_busy = busy;
      if (in_ready !== 1'b0) break;
      low++;
    end
    chk({nm, ".busy"},    {63'd0, saw_busy},  64'd1);
    chk({nm, ".latency"}, 64'(low),           64'd33);
    chk({nm, ".valid"},   {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    chk({nm, ".pulse_end"}, {63'd0, out_valid}, 64'd0);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst.valid",    {63'd0, out_valid},  64'd0);
    chk("rst.result",   {32'd0, out_result}, 64'd0);
    chk("rst.hi",       {32'd0, out_hi},     64'd0);
    chk("rst.equal",    {63'd0, out_equal},  64'd0);
    chk("rst.busy",     {63'd0, busy},       64'd0);
    chk("rst.in_ready", {63'd0, in_ready},   64'd1);

    sc_op("add_wrap", OP_ADD, SEL_A_RS, SEL_B_IMM, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    sc_op("sub_fwd",  OP_SUB, SEL_A_FWD_MEM, SEL_B_FWD_WB, 32'd5, 32'd5, 32'd0, 1'b1);
    sc_op("slt_neg",  OP_SLT, SEL_A_RS, SEL_B_RT, 32'hFFFF_FFFB, 32'd3, 32'd1, 1'b0);
    // Hold between pulses.
    @(negedge clk);
    chk("hold.valid",  {63'd0, out_valid},  64'd0);
    chk("hold.result", {32'd0, out_result}, 64'd1);
    sc_op("slt_pos",  OP_SLT, SEL_A_RS, SEL_B_RT, 32'd3, 32'hFFFF_FFFB, 32'd0, 1'b0);
    sc_op("and",  OP_AND, SEL_A_RS, SEL_B_RT, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    sc_op("or",   OP_OR,  SEL_A_RS, SEL_B_RT, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
    sc_op("xor",  OP_XOR, SEL_A_RS, SEL_B_RT, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    // Only the low 5 bits of B shift: 0x24 -> 4.
    sc_op("sll",  OP_SLL, SEL_A_RS, SEL_B_RT, 32'h8000_0001, 32'h0000_0024, 32'h0000_0010, 1'b0);
    sc_op("srl",  OP_SRL, SEL_A_RS, SEL_B_RT, 32'h8000_0001, 32'h0000_0024, 32'h0800_0000, 1'b0);
    sc_op("npc_add", OP_ADD, SEL_A_NPC, SEL_B_IMM, 32'h0000_1000, 32'h0000_0004, 32'h0000_1004, 1'b0);
    sc_op("illegal", 6'd12, SEL_A_RS, SEL_B_RT, 32'h0000_0077, 32'h0000_0077, 32'd0, 1'b1);

    // Flush with a simultaneous offer drops it; a stray pulse is caught by the monitor.
    @(negedge clk);
    alu_op = OP_ADD; sel_a = SEL_A_RS; sel_b = SEL_B_RT;
    rs_data = 32'd1; rt_data = 32'd2;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_drop.valid", {63'd0, out_valid}, 64'd0);

`ifdef EX_STAGE_MULDIV_EN
    md_op("mulu",     OP_MULU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1);
    md_op("divu",     OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
    md_op("divu_by0", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9);

    // Flush mid-divide: no pulse, ready again right away, next ADD normal.
    issue("divu_flush", OP_DIVU, SEL_A_RS, SEL_B_RT, 32'd100, 32'd7, 0, 0, 0, 0,
          1'b0, 32'd0, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("divu_flush.in_ready", {63'd0, in_ready}, 64'd1);
    chk("divu_flush.busy",     {63'd0, busy},     64'd0);
    repeat (40) @(negedge clk);
    sc_op("add_after_flush", OP_ADD, SEL_A_RS, SEL_B_RT, 32'd20, 32'd22, 32'd42, 1'b0);

    // Reset in the middle of a multiply.
    issue("mulu_rst", OP_MULU, SEL_A_RS, SEL_B_RT, 32'd3, 32'd4, 0, 0, 0, 0,
          1'b0, 32'd0, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst.result",   {32'd0, out_result}, 64'd0);
    chk("mid_rst.valid",    {63'd0, out_valid},  64'd0);
    chk("mid_rst.busy",     {63'd0, busy},       64'd0);
    chk("mid_rst.in_ready", {63'd0, in_ready},   64'd1);
    repeat (40) @(negedge clk);
`else
    // Without the mul/div path, 8/9 act as illegal single-cycle ops.
    sc_op("mulu_illegal", OP_MULU, SEL_A_RS, SEL_B_RT, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0);
    sc_op("divu_illegal", OP_DIVU, SEL_A_RS, SEL_B_RT, 32'd9, 32'd9, 32'd0, 1'b1);
    chk("no_md.in_ready", {63'd0, in_ready}, 64'd1);
    chk("no_md.busy",     {63'd0, busy},     64'd0);

    sc_op("pre_rst_add", OP_ADD, SEL_A_RS, SEL_B_RT, 32'd20, 32'd22, 32'd42, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2.result", {32'd0, out_result}, 64'd0);
    chk("rst2.valid",  {63'd0, out_valid},  64'd0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
